// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock,
// with valid/ready handshakes and an optional two's-complement magnitude/sign mode.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int DW = 4 * DIGITS;
  localparam int SW = DW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [SW-1:0]    sreg;
  logic [SW-1:0]    sadj;
  logic [SW-1:0]    snext;
  logic [CW-1:0]    cnt;
  logic             neg_int;
  logic             is_neg;
  logic [WIDTH-1:0] mag;

  // Negation on WIDTH bits read as unsigned maps -2^(WIDTH-1) to 2^(WIDTH-1).
  always_comb begin
    is_neg = (SIGNED != 0) && bin[WIDTH-1];
    mag    = is_neg ? ('0 - bin) : bin;
  end

  // All digits are adjusted from pre-iteration values, then the register shifts.
  always_comb begin
    sadj = sreg;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sreg[WIDTH+4*i +: 4] >= 4'd5)
        sadj[WIDTH+4*i +: 4] = sreg[WIDTH+4*i +: 4] + 4'd3;
    end
    snext = {sadj[SW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
      neg_int   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= {{DW{1'b0}}, mag};
            neg_int  <= is_neg;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= snext;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd       <= snext[SW-1 -: DW];
            neg       <= neg_int;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
